// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide engine owning HI/LO.
// A MULT/DIV runs for WIDTH iterations plus one sign-fixup cycle; busy is
// high while it runs and done pulses when hi/lo are written. A divide by zero
// is reported at once (done + divby0) and leaves hi/lo untouched.
// Ports:
//   clock, reset         clock, synchronous active-high reset
//   start, op            request; op = 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a/operand_b  multiplicand/dividend, multiplier/divisor
//   wr_hi, wr_lo, wdata  MTHI/MTLO writes (honoured only while idle)
//   busy, done, divby0   handshake and divide-by-zero pulse
//   hi, lo               HI/LO registers
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divby0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_dvd_q, neg_dvd_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              divby0_q, divby0_d;

    // Operand magnitudes; unsigned ops (op[0]) pass the raw value through.
    logic [WIDTH-1:0]  mag_a, mag_b;
    assign mag_a = (!op[0] && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign mag_b = (!op[0] && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]    mul_sum;
    logic [W2-1:0]     mul_next;
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: acc = {remainder, dividend/quotient bits}.
    // The trial difference's top bit is the borrow, i.e. remainder < divisor.
    logic [WIDTH:0]    div_top, div_trial;
    logic              div_ge;
    logic [WIDTH-1:0]  div_rem;
    logic [W2-1:0]     div_next;
    assign div_top   = acc_q[W2-1:WIDTH-1];
    assign div_trial = div_top - {1'b0, b_q};
    assign div_ge    = ~div_trial[WIDTH];
    assign div_rem   = div_ge ? div_trial[WIDTH-1:0] : div_top[WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    // Signed fix-up values used on the FIN edge.
    logic [W2-1:0]     prod_fix;
    logic [WIDTH-1:0]  quo_fix, rem_fix;
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_dvd_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_dvd_d = neg_dvd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divby0_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start) begin
                    if (op[1] && (operand_b == '0)) begin
                        done_d   = 1'b1;
                        divby0_d = 1'b1;
                    end else begin
                        is_div_d  = op[1];
                        neg_res_d = !op[0] && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        neg_dvd_d = !op[0] && operand_a[WIDTH-1];
                        acc_d     = {{WIDTH{1'b0}}, mag_a};
                        b_d       = mag_b;
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIN;
            end
            S_FIN: begin
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[W2-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_dvd_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divby0_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_dvd_q <= neg_dvd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divby0_q  <= divby0_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign divby0 = divby0_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): expected hi/lo/divby0 are
// queued at issue time and popped by a monitor on every done pulse.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  operand_a = '0;
    logic [W-1:0]  operand_b = '0;
    logic          wr_hi = 1'b0;
    logic          wr_lo = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          busy, done, divby0;
    logic [W-1:0]  hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .divby0    (divby0),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".hi"}, hi, e.hi);
                chk({e.name, ".lo"}, lo, e.lo);
                chk({e.name, ".divby0"}, W'(divby0), W'(e.dz));
            end
        end else if (!reset && divby0) begin
            n_vec++;
            n_miss++;
            $display("FAIL divby0_without_done: got divby0=1 done=%0b expected both or neither", done);
        end
    end

    // Called at a negedge: drive a request for one edge, return at next negedge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic whi, input logic wlo, input logic [W-1:0] wd);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        wr_hi = whi; wr_lo = wlo; wdata = wd;
        @(negedge clock);
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        operand_a = '0; operand_b = '0;
    endtask

    // Count negedges from n0 until done; check latency, busy length and pulse width.
    task automatic wait_done(input string name, input int n0, input int exp_lat, input int exp_busy);
        int  n = n0;
        int  bcnt = n0 - 1;
        bit  seen = 1'b0;
        while (n <= 80 && !seen) begin
            if (busy) bcnt++;
            if (done) seen = 1'b1;
            else begin
                n++;
                @(negedge clock);
            end
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s.timeout: got no done within 80 cycles expected done at %0d", name, exp_lat);
        end else begin
            chk({name, ".latency"}, W'(n), W'(exp_lat));
            chk({name, ".busy_cycles"}, W'(bcnt), W'(exp_busy));
            @(negedge clock);
            chk({name, ".done_width"}, W'(done), W'(0));
            chk({name, ".busy_after"}, W'(busy), W'(0));
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edz);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.name = name;
        exp_q.push_back(e);
        issue(o, a, b, 1'b0, 1'b0, '0);
        if (edz) wait_done(name, 1, 1, 0);
        else     wait_done(name, 1, W + 2, W + 1);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clock);
        chk("reset.hi", hi, '0);
        chk("reset.lo", lo, '0);
        chk("reset.busy", W'(busy), W'(0));
        chk("reset.done", W'(done), W'(0));
        chk("reset.divby0", W'(divby0), W'(0));
        reset = 1'b0;
        @(negedge clock);

        run_op("mult_neg3x5",  2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("multu_ffxff",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_m1xm1",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
        run_op("div_m7d2",     2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu_100d7",   2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        run_op("div_min_dm1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("div_7dm2",     2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);

        // MTHI while idle, then divide by zero leaves hi/lo alone.
        wr_hi = 1'b1; wdata = 32'h12345678;
        @(negedge clock);
        wr_hi = 1'b0;
        chk("mthi.hi", hi, 32'h12345678);
        chk("mthi.lo", lo, 32'hFFFFFFFD);
        run_op("div_by0", 2'b10, 32'h00000055, 32'h0, 32'h12345678, 32'hFFFFFFFD, 1'b1);

        // MTLO on the same edge as a DIVU-by-zero start still applies.
        e.hi = 32'h12345678; e.lo = 32'hA5A5A5A5; e.dz = 1'b1; e.name = "divu_by0_mtlo";
        exp_q.push_back(e);
        issue(2'b11, 32'h1, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5);
        wait_done("divu_by0_mtlo", 1, 1, 0);

        // Second start and MTLO while busy are both ignored.
        e.hi = 32'h0; e.lo = 32'h00012340; e.dz = 1'b0; e.name = "mult_busy_ignore";
        exp_q.push_back(e);
        issue(2'b00, 32'h00001234, 32'h00000010, 1'b0, 1'b0, '0);
        repeat (8) @(negedge clock);
        chk("busy_mid_op", W'(busy), W'(1));
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hDEADBEEF);
        wait_done("mult_busy_ignore", 10, W + 2, W + 1);
        wr_lo = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clock);
        wr_lo = 1'b0;
        chk("mtlo.lo", lo, 32'hDEADBEEF);
        chk("mtlo.hi", hi, 32'h0);

        // Reset in the middle of a DIVU abandons it with no done.
        issue(2'b11, 32'd1000, 32'd3, 1'b0, 1'b0, '0);
        repeat (13) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midreset.busy", W'(busy), W'(0));
        chk("midreset.hi", hi, '0);
        chk("midreset.lo", lo, '0);
        chk("midreset.done", W'(done), W'(0));
        repeat (40) @(negedge clock);
        chk("midreset.idle", W'(busy), W'(0));

        run_op("mult_6x7", 2'b00, 32'd6, 32'd7, 32'h0, 32'h0000002A, 1'b0);

        chk("scoreboard_drained", W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine that owns the HI/LO pair for the multicycle CPU datapath.
- Replaces the separate fixed-32-bit multiplier, divider and HI/LO registers with one block.
- Supports signed and unsigned MULT/DIV, MTHI/MTLO writes, a busy/done handshake and divide-by-zero reporting.
- The control unit stalls on busy and samples divby0 to raise the exception.

Parameters:
- WIDTH, 32: operand width in bits; hi, lo and operands are WIDTH bits wide; WIDTH must be >= 4.
- CNT_W, $clog2(WIDTH)+1: width of the internal iteration counter.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- operand_a  input  WIDTH  multiplicand / dividend (rs).
- operand_b  input  WIDTH  multiplier / divisor (rt).
- wr_hi  input  1  MTHI: load hi from wdata.
- wr_lo  input  1  MTLO: load lo from wdata.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: hi/lo updated, or divide-by-zero detected.
- divby0  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with operand_b == 0.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset: synchronous, active-high, wins over every other input. State IDLE; hi = lo = 0; busy = done = divby0 = 0; internal accumulators and counter cleared. A reset during RUN or FIN abandons the operation with no hi/lo write.
- States: IDLE, RUN, FIN.
- IDLE, edge with start = 1, divide op, operand_b == 0:
  - Stay in IDLE; done = 1 and divby0 = 1 for the following cycle.
  - hi and lo unchanged.
- IDLE, edge with start = 1, otherwise:
  - Capture |a| and |b|. Signed ops take the two's-complement magnitude; unsigned ops take the raw value.
  - Record the sign of the result and the sign of the dividend.
  - Counter = WIDTH; go to RUN; busy = 1.
- RUN: one iteration per edge, counter decrements, go to FIN when the counter reaches 1 (exactly WIDTH RUN edges).
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per edge.
- FIN, one edge:
  - Apply sign correction.
  - Multiply: {hi,lo} = product, negated if signs differ.
  - Divide: lo = quotient, negated if signs differ (truncation toward zero); hi = remainder, negated if the dividend was negative.
  - Go to IDLE; busy = 0; done = 1 for the following cycle.
- Latency: start edge to done visible = WIDTH+2 edges (34 for WIDTH=32); busy is high for WIDTH+1 cycles.
- Overflow case (DIV of most-negative by -1) is not an error: lo = most-negative, hi = 0. No overflow flag.
- start while busy is ignored and not queued. op and operands are used only at the start edge; later changes have no effect.
- wr_hi / wr_lo:
  - Honoured only when busy = 0, i.e. in IDLE, including the same edge as an accepted start.
  - Ignored while busy.
  - Same edge as a divide-by-zero start: the write still applies.
- Outputs are registered; hi and lo change only on MTHI/MTLO, FIN or reset.

Test Plan (WIDTH=32):
- MULT a=FFFFFFFD (-3), b=00000005 -> busy for 33 cycles, done pulse after edge 34; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; repeat as MULT -> hi=00000000, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
- Preload hi=12345678 with wr_hi, then DIV with b=0 -> done and divby0 high for exactly 1 cycle one edge after start; busy stays 0; hi=12345678 unchanged.
- Start MULT; at cycle 10 assert start with new operands plus wr_lo=1, wdata=DEADBEEF -> both ignored; result is the first operation's. Then in IDLE: wr_lo -> lo=DEADBEEF next cycle.
- Reset asserted at cycle 15 of a DIVU -> next cycle busy=0, hi=lo=0, no done pulse. A fresh MULT 6*7 then gives lo=0000002A, hi=0 with normal latency.
